// File: rtl/i2c_bus_mon_if.sv
// Signal bundle for the I2C bus-line monitor: raw pads and runtime
// configuration towards the monitor, filtered levels and event strobes back.
interface i2c_bus_mon_if #(
    parameter int unsigned DB_W  = 14,
    parameter int unsigned CNT_W = 32
);
    logic             scl_pad_i;
    logic             sda_pad_i;
    logic [DB_W-1:0]  debounce_cnt;
    logic [CNT_W-1:0] tidle;
    logic [CNT_W-1:0] ttimeout;
    logic             gauge_en;

    logic             scl_f;
    logic             sda_f;
    logic             scl_rising;
    logic             scl_falling;
    logic             sta_det;
    logic             sto_det;
    logic             busy;
    logic             idle_det;
    logic [CNT_W-1:0] thigh;
    logic [CNT_W-1:0] tlow;
    logic             thigh_vld;
    logic             tlow_vld;
    logic             timeout;

    modport master (
        output scl_pad_i, sda_pad_i, debounce_cnt, tidle, ttimeout, gauge_en,
        input  scl_f, sda_f, scl_rising, scl_falling, sta_det, sto_det, busy,
               idle_det, thigh, tlow, thigh_vld, tlow_vld, timeout
    );

    modport slave (
        input  scl_pad_i, sda_pad_i, debounce_cnt, tidle, ttimeout, gauge_en,
        output scl_f, sda_f, scl_rising, scl_falling, sta_det, sto_det, busy,
               idle_det, thigh, tlow, thigh_vld, tlow_vld, timeout
    );
endinterface

// File: rtl/i2c_bus_mon.sv
// I2C bus-line front end: synchronise and debounce SCL/SDA, then derive edge,
// START/STOP, busy, idle, SCL period gauge and SCL-low timeout indications.
module i2c_bus_mon #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_W        = 14,
    parameter int unsigned CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rstn,
    i2c_bus_mon_if.slave bus
);
    // Line index 0 is SCL, index 1 is SDA.
    localparam int unsigned NL = 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NL-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NL-1:0]                  line_s;
    logic [NL-1:0][DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [NL-1:0]                  line_f_q, line_f_d;

    logic             scl_rise_q, scl_rise_d;
    logic             scl_fall_q, scl_fall_d;
    logic             sta_q, sta_d;
    logic             sto_q, sto_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             idle_det_q, idle_det_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] thigh_q, thigh_d;
    logic [CNT_W-1:0] tlow_q, tlow_d;
    logic             thigh_vld_q, thigh_vld_d;
    logic             tlow_vld_q, tlow_vld_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic             timeout_q, timeout_d;

    logic scl_cur, scl_nxt, sda_cur, sda_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Pad synchronisers, idle-high so reset does not look like a bus event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= {sync_q[0][SYNC_STAGES-2:0], bus.scl_pad_i};
            sync_q[1] <= {sync_q[1][SYNC_STAGES-2:0], bus.sda_pad_i};
        end
    end

    assign line_s = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

    // Debounce: accept a new level only after it persisted debounce_cnt+1 cycles.
    always_comb begin
        line_f_d = line_f_q;
        db_cnt_d = '0;
        for (int l = 0; l < int'(NL); l++) begin
            if (line_s[l] != line_f_q[l]) begin
                if (db_cnt_q[l] >= bus.debounce_cnt) begin
                    line_f_d[l] = line_s[l];
                end else begin
                    db_cnt_d[l] = db_cnt_q[l] + DB_W'(1);
                end
            end
        end
    end

    // Event logic works on the level being registered (nxt) against the current one.
    always_comb begin
        scl_cur = line_f_q[0];
        scl_nxt = line_f_d[0];
        sda_cur = line_f_q[1];
        sda_nxt = line_f_d[1];

        scl_rise_d  = scl_nxt & ~scl_cur;
        scl_fall_d  = ~scl_nxt & scl_cur;
        sta_d       = scl_cur & scl_nxt & sda_cur & ~sda_nxt;
        sto_d       = scl_cur & scl_nxt & ~sda_cur & sda_nxt;

        idle_cnt_d  = '0;
        idle_det_d  = 1'b0;
        if (scl_nxt && sda_nxt) begin
            if ((bus.tidle != '0) && (idle_cnt_q == bus.tidle)) begin
                idle_cnt_d = idle_cnt_q;
            end else begin
                idle_cnt_d = sat_inc(idle_cnt_q);
                idle_det_d = (bus.tidle != '0) && (idle_cnt_d == bus.tidle);
            end
        end

        busy_d = sta_d | (busy_q & ~(sto_d | idle_det_d));

        // Gauge: a period is reported only when both bounding edges were seen enabled.
        per_cnt_d   = per_cnt_q;
        armed_d     = armed_q;
        thigh_d     = thigh_q;
        tlow_d      = tlow_q;
        thigh_vld_d = 1'b0;
        tlow_vld_d  = 1'b0;
        if (!bus.gauge_en) begin
            per_cnt_d = '0;
            armed_d   = 1'b0;
        end else if (scl_rise_d || scl_fall_d) begin
            per_cnt_d = CNT_ONE;
            armed_d   = 1'b1;
            if (armed_q) begin
                if (scl_fall_d) begin
                    thigh_d     = per_cnt_q;
                    thigh_vld_d = 1'b1;
                end else begin
                    tlow_d     = per_cnt_q;
                    tlow_vld_d = 1'b1;
                end
            end
        end else begin
            per_cnt_d = sat_inc(per_cnt_q);
        end

        low_cnt_d = '0;
        if (!scl_nxt) begin
            low_cnt_d = scl_cur ? CNT_ONE : sat_inc(low_cnt_q);
        end

        timeout_d = timeout_q;
        if ((bus.ttimeout == '0) || scl_rise_d) begin
            timeout_d = 1'b0;
        end else if (!scl_nxt && (low_cnt_d >= bus.ttimeout)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_cnt_q    <= '0;
            line_f_q    <= '1;
            scl_rise_q  <= 1'b0;
            scl_fall_q  <= 1'b0;
            sta_q       <= 1'b0;
            sto_q       <= 1'b0;
            busy_q      <= 1'b0;
            idle_cnt_q  <= '0;
            idle_det_q  <= 1'b0;
            per_cnt_q   <= '0;
            armed_q     <= 1'b0;
            thigh_q     <= '0;
            tlow_q      <= '0;
            thigh_vld_q <= 1'b0;
            tlow_vld_q  <= 1'b0;
            low_cnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            line_f_q    <= line_f_d;
            scl_rise_q  <= scl_rise_d;
            scl_fall_q  <= scl_fall_d;
            sta_q       <= sta_d;
            sto_q       <= sto_d;
            busy_q      <= busy_d;
            idle_cnt_q  <= idle_cnt_d;
            idle_det_q  <= idle_det_d;
            per_cnt_q   <= per_cnt_d;
            armed_q     <= armed_d;
            thigh_q     <= thigh_d;
            tlow_q      <= tlow_d;
            thigh_vld_q <= thigh_vld_d;
            tlow_vld_q  <= tlow_vld_d;
            low_cnt_q   <= low_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.scl_f       = line_f_q[0];
    assign bus.sda_f       = line_f_q[1];
    assign bus.scl_rising  = scl_rise_q;
    assign bus.scl_falling = scl_fall_q;
    assign bus.sta_det     = sta_q;
    assign bus.sto_det     = sto_q;
    assign bus.busy        = busy_q;
    assign bus.idle_det    = idle_det_q;
    assign bus.thigh       = thigh_q;
    assign bus.tlow        = tlow_q;
    assign bus.thigh_vld   = thigh_vld_q;
    assign bus.tlow_vld    = tlow_vld_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_i2c_bus_mon.sv
// Directed bench for i2c_bus_mon: debounce, START/STOP, gauge scoreboard,
// idle release, SCL-low timeout and asynchronous reset.
module tb_i2c_bus_mon;
    localparam int unsigned DB_W  = 14;
    localparam int unsigned CNT_W = 32;

    localparam int W_STA  = 0;
    localparam int W_STO  = 1;
    localparam int W_IDLE = 2;
    localparam int W_FALL = 3;
    localparam int W_RISE = 4;

    typedef struct {
        bit          is_high;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    i2c_bus_mon_if #(.DB_W(DB_W), .CNT_W(CNT_W)) bus ();

    i2c_bus_mon #(.SYNC_STAGES(2), .DB_W(DB_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit hi, input logic [31:0] v);
        exp_t e;
        e.is_high = hi;
        e.val     = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input bit hi, input logic [31:0] obs);
        exp_t e;
        chk(hi ? "sb_thigh_expected" : "sb_tlow_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_kind", 64'(hi), 64'(e.is_high));
            chk(hi ? "sb_thigh" : "sb_tlow", 64'(obs), 64'(e.val));
        end
    endtask

    // Scoreboard consumer for gauge results.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.thigh_vld) sb_check(1'b1, bus.thigh);
            if (bus.tlow_vld)  sb_check(1'b0, bus.tlow);
        end
    end

    task automatic wait_for(input string tag, input int which, input int bound, output int k);
        bit seen;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < bound) begin
            step(1);
            k++;
            case (which)
                W_STA:   seen = bus.sta_det;
                W_STO:   seen = bus.sto_det;
                W_IDLE:  seen = bus.idle_det;
                W_FALL:  seen = bus.scl_falling;
                W_RISE:  seen = bus.scl_rising;
                default: seen = 1'b0;
            endcase
        end
        chk({tag, "_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic check_reset(input string p);
        chk({p, "_scl_f"},     64'(bus.scl_f),       64'(1));
        chk({p, "_sda_f"},     64'(bus.sda_f),       64'(1));
        chk({p, "_busy"},      64'(bus.busy),        64'(0));
        chk({p, "_thigh"},     64'(bus.thigh),       64'(0));
        chk({p, "_tlow"},      64'(bus.tlow),        64'(0));
        chk({p, "_timeout"},   64'(bus.timeout),     64'(0));
        chk({p, "_strobes"},   64'({bus.scl_rising, bus.scl_falling, bus.sta_det, bus.sto_det,
                                     bus.idle_det, bus.thigh_vld, bus.tlow_vld}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen_a;
        bit  seen_b;
        checks   = 0;
        failures = 0;
        rstn             = 1'b0;
        bus.scl_pad_i    = 1'b1;
        bus.sda_pad_i    = 1'b1;
        bus.debounce_cnt = DB_W'(3);
        bus.tidle        = '0;
        bus.ttimeout     = '0;
        bus.gauge_en     = 1'b0;
        #23;
        check_reset("rst0");
        step(1);
        rstn = 1'b1;
        step(5);

        // 3-cycle low glitch is rejected with debounce_cnt=3.
        seen_a = 1'b0;
        bus.scl_pad_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen_a |= ~bus.scl_f | bus.scl_falling;
        end
        bus.scl_pad_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen_a |= ~bus.scl_f | bus.scl_falling;
        end
        chk("glitch_rejected", 64'(seen_a), 64'(0));

        // 4+ cycle low passes after 2+3+1 cycles.
        bus.scl_pad_i = 1'b0;
        step(5);
        chk("db_lat_before", 64'(bus.scl_f), 64'(1));
        step(1);
        chk("db_lat_scl_f", 64'(bus.scl_f), 64'(0));
        chk("db_lat_fall", 64'(bus.scl_falling), 64'(1));
        step(1);
        chk("db_fall_one_cycle", 64'(bus.scl_falling), 64'(0));
        bus.scl_pad_i = 1'b1;
        step(8);
        bus.debounce_cnt = '0;
        step(3);

        // START then STOP.
        bus.sda_pad_i = 1'b0;
        wait_for("sta", W_STA, 10, k);
        chk("sta_busy", 64'(bus.busy), 64'(1));
        chk("sta_sda_f", 64'(bus.sda_f), 64'(0));
        step(3);
        bus.sda_pad_i = 1'b1;
        wait_for("sto", W_STO, 10, k);
        chk("sto_busy", 64'(bus.busy), 64'(0));
        step(3);

        // Simultaneous SCL/SDA fall is not a START.
        seen_a = 1'b0;
        bus.scl_pad_i = 1'b0;
        bus.sda_pad_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            seen_a |= bus.sta_det;
        end
        chk("simul_no_sta", 64'(seen_a), 64'(0));
        chk("simul_busy", 64'(bus.busy), 64'(0));
        bus.scl_pad_i = 1'b1;
        bus.sda_pad_i = 1'b1;
        step(5);

        // Gauge: 15 low / 10 high; first edge only arms.
        bus.gauge_en = 1'b1;
        step(2);
        for (int r = 0; r < 4; r++) begin
            bus.scl_pad_i = 1'b0;
            if (r > 0) push(1'b1, 32'd10);
            step(15);
            bus.scl_pad_i = 1'b1;
            push(1'b0, 32'd15);
            step(10);
        end
        bus.gauge_en = 1'b0;
        step(2);
        chk("gauge_sb_drained", 64'(sb_q.size()), 64'(0));
        chk("gauge_thigh_hold", 64'(bus.thigh), 64'(10));
        chk("gauge_tlow_hold", 64'(bus.tlow), 64'(15));

        // Idle release: START, bus returns high without STOP for tidle cycles.
        bus.tidle = CNT_W'(50);
        bus.sda_pad_i = 1'b0;
        wait_for("idle_sta", W_STA, 10, k);
        chk("idle_sta_busy", 64'(bus.busy), 64'(1));
        bus.scl_pad_i = 1'b0;
        step(5);
        bus.sda_pad_i = 1'b1;
        step(5);
        bus.scl_pad_i = 1'b1;
        wait_for("idle_rise", W_RISE, 10, k);
        wait_for("idle_det", W_IDLE, 80, k);
        chk("idle_latency", 64'(k), 64'(49));
        chk("idle_busy_clear", 64'(bus.busy), 64'(0));

        // START just before tidle expires keeps the bus busy.
        bus.sda_pad_i = 1'b0;
        wait_for("idle2_sta", W_STA, 10, k);
        bus.scl_pad_i = 1'b0;
        step(5);
        bus.sda_pad_i = 1'b1;
        step(5);
        bus.scl_pad_i = 1'b1;
        wait_for("idle2_rise", W_RISE, 10, k);
        step(44);
        bus.sda_pad_i = 1'b0;
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            seen_a |= bus.idle_det;
            seen_b |= bus.sta_det;
        end
        chk("late_sta_no_idle", 64'(seen_a), 64'(0));
        chk("late_sta_seen", 64'(seen_b), 64'(1));
        chk("late_sta_busy", 64'(bus.busy), 64'(1));
        bus.sda_pad_i = 1'b1;
        wait_for("idle2_sto", W_STO, 10, k);
        bus.tidle = '0;
        chk("idle2_sto_busy", 64'(bus.busy), 64'(0));

        // SCL-low timeout.
        bus.ttimeout = CNT_W'(100);
        bus.scl_pad_i = 1'b0;
        wait_for("to_fall", W_FALL, 10, k);
        step(98);
        chk("timeout_at_99", 64'(bus.timeout), 64'(0));
        step(1);
        chk("timeout_at_100", 64'(bus.timeout), 64'(1));
        bus.scl_pad_i = 1'b1;
        wait_for("to_rise", W_RISE, 10, k);
        chk("timeout_clr_rise", 64'(bus.timeout), 64'(0));
        bus.ttimeout = '0;
        bus.scl_pad_i = 1'b0;
        seen_a = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            seen_a |= bus.timeout;
        end
        chk("timeout_disabled", 64'(seen_a), 64'(0));
        bus.scl_pad_i = 1'b1;
        step(5);

        // Reset mid-transfer with busy=1 and thigh=10.
        bus.gauge_en = 1'b1;
        bus.sda_pad_i = 1'b0;
        wait_for("mid_sta", W_STA, 10, k);
        bus.scl_pad_i = 1'b0;
        step(15);
        bus.scl_pad_i = 1'b1;
        push(1'b0, 32'd15);
        step(10);
        bus.scl_pad_i = 1'b0;
        push(1'b1, 32'd10);
        step(6);
        chk("mid_thigh", 64'(bus.thigh), 64'(10));
        chk("mid_busy", 64'(bus.busy), 64'(1));
        #2;
        rstn = 1'b0;
        #1;
        check_reset("rst_mid");
        bus.scl_pad_i = 1'b1;
        bus.sda_pad_i = 1'b1;
        step(3);
        rstn = 1'b1;
        step(5);
        chk("post_rst_sb_drained", 64'(sb_q.size()), 64'(0));
        chk("post_rst_thigh", 64'(bus.thigh), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_bus_mon.md
# i2c_bus_mon

Parametrised I2C bus-line front end that replaces the fixed debounce/monitor stage feeding the bit controller. It synchronises and glitch-filters raw SCL/SDA pad inputs, then produces SCL edge strobes, START/STOP detection and bus-busy tracking. It adds an SCL high/low period gauge with valid strobes, an idle-based busy release and an SMBus-style SCL-low timeout. Counter widths and synchroniser depth are configurable.

## Interface
- SYNC_STAGES, 2, synchroniser flops per line (≥2)
- DB_W, 14, debounce counter width
- CNT_W, 32, gauge/idle/timeout counter width

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset; one clock domain, reset is asynchronous and active-low
- scl_pad_i  in  1  raw SCL pad input
- sda_pad_i  in  1  raw SDA pad input
- debounce_cnt  in  DB_W  filter length in cycles (0 = no filtering beyond 1 cycle)
- tidle  in  CNT_W  cycles of SCL=SDA=1 that force bus free; 0 disables
- ttimeout  in  CNT_W  cycles of SCL low that raise timeout; 0 disables
- gauge_en  in  1  enable SCL period measurement
- scl_f, sda_f  out  1 each  filtered line levels
- scl_rising, scl_falling  out  1 each  one-cycle edge strobes of scl_f
- sta_det, sto_det  out  1 each  one-cycle START/STOP strobes
- busy  out  1  bus owned (START seen, no STOP/idle since)
- idle_det  out  1  one-cycle strobe when tidle expires
- thigh, tlow  out  CNT_W each  last measured SCL high/low period in cycles
- thigh_vld, tlow_vld  out  1 each  one-cycle strobe on thigh/tlow update
- timeout  out  1  SCL held low ≥ ttimeout cycles

## Operation
- Synchroniser: SYNC_STAGES flops per line, reset to 1.
- Debounce, per line independently: counter increments each cycle synchronised value ≠ filtered value; clears whenever equal; when counter == debounce_cnt, filtered ← synchronised and counter clears. Pulses shorter than debounce_cnt+1 cycles are rejected. Changing debounce_cnt mid-run takes effect next cycle; a counter already above a new smaller value updates on the next mismatching cycle.
- Edge strobes: asserted in the first cycle scl_f shows the new level.
- START: sda_f 1→0 while scl_f high in both that cycle and the previous one. STOP: sda_f 0→1 under the same condition. Same-cycle SCL and SDA filtered changes produce neither.
- busy: set by sta_det (including repeated START), cleared by sto_det or idle_det; set wins over clear in the same cycle.
- Idle: counter runs while scl_f=sda_f=1, clears otherwise; idle_det pulses once when count reaches tidle (tidle≠0), then the counter holds until either line drops.
- Gauge: period counter loads 1 on every scl_f edge, increments otherwise, saturates at 2^CNT_W−1. On scl_falling: thigh ← counter value, thigh_vld pulses. On scl_rising: tlow ← counter, tlow_vld pulses. Only periods bounded by two edges both seen with gauge_en=1 are reported; the first edge after enable only arms. gauge_en=0: counter cleared, disarmed, thigh/tlow hold.
- Timeout: low counter runs while scl_f=0, saturating. timeout sets when count reaches ttimeout (ttimeout≠0) and clears on scl_rising or when ttimeout is written to 0.

## Timing
- Reset values: scl_f=sda_f=1, busy=0, thigh=tlow=0, timeout=0, all strobes 0, all counters 0.
- All outputs registered. Pad→scl_f/sda_f latency = SYNC_STAGES + debounce_cnt + 1 cycles.
- Strobes are exactly one cycle and never coincide for the same line's opposite edge.
- Reset mid-operation: all state returns to reset values immediately. The first edge after release is not gauged.
- A measured period of N cycles reports value N (SCL high exactly 5 filtered cycles → thigh=5).

## Test plan
- debounce_cnt=3, SCL pad low glitch of 3 cycles → scl_f stays 1, no strobe. 4-cycle low → scl_f falls 2+3+1=6 cycles after pad edge, scl_falling one cycle.
- SDA falls with SCL high, later SDA rises with SCL high → sta_det then sto_det, busy 0→1→0. Simultaneous SCL/SDA fall → no sta_det.
- gauge_en=1, debounce_cnt=0, SCL 10 cycles high / 15 low, repeated → after arming, thigh=10 with thigh_vld and tlow=15 with tlow_vld each period.
- tidle=50, START then both lines high 50 cycles without STOP → idle_det pulse, busy=0. START at cycle 49 → busy stays 1.
- ttimeout=100, SCL held low 100 cycles → timeout=1 at cycle 100. SCL release → timeout=0 on scl_rising. ttimeout=0 → never asserts.
- Assert rstn mid-transfer with busy=1 and thigh=10 → all outputs return to reset values asynchronously.
